// File: rtl/scdmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding,
// wait-counter width and the byte-lane merge helper.
package scdmem_pkg;

  // Width of the wait-state counter (WAIT legal range 0..15).
  localparam int CNT_W = 4;

  // Responder FSM states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Replace the byte lanes of old_word selected by be with those of new_word.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/scdmem_array.sv
// Word array for the responder: synchronous byte-enabled write,
// asynchronous read, every word cleared while clrn_i is high.
module scdmem_array
  import scdmem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk_i,
  input  logic                  clrn_i,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  input  logic [3:0]            be_i,
  output logic [31:0]           rdata_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [31:0] mem_q [DEPTH];

  // Storage: clear on reset, merge enabled lanes on a write strobe.
  always_ff @(posedge clk_i or posedge clrn_i) begin
    if (clrn_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'h0000_0000;
      end
    end else if (we_i) begin
      mem_q[addr_i] <= byte_merge(mem_q[addr_i], wdata_i, be_i);
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/scdmem_resp.sv
// Data-memory responder: req/ack handshake with programmable wait states,
// byte-enabled writes, word reads and misaligned/out-of-range detection.
// The array access and error decision happen in the RESP cycle; ack, err,
// rdata and busy are registered from that cycle, so ack shows up one cycle
// later and the requester sees it WAIT+1 cycles after the accept edge.
module scdmem_resp
  import scdmem_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 6,
  parameter int unsigned WAIT       = 2,
  parameter logic [31:0] BASE       = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept_s;

  logic               we_q;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;
  logic [3:0]         be_q;

  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic [31:0]        rdata_q, rdata_d;

  logic               low_borrow_s;
  logic [30:0]        diff_s;
  logic               oor_s;
  logic               err_s;
  logic               mem_we_s;
  logic [31:0]        mem_rdata_s;

  // Word offset from BASE with the borrow kept in the top bit:
  // (addr-BASE)>>2 computed on the upper bits plus the low-bit borrow.
  assign low_borrow_s = (addr_q[1:0] < BASE[1:0]);
  assign diff_s       = {1'b0, addr_q[31:2]} - {1'b0, BASE[31:2]} - {30'd0, low_borrow_s};
  assign oor_s        = diff_s[30] | (|diff_s[29:DEPTH_LOG2]);
  assign err_s        = (addr_q[1:0] != 2'b00) | oor_s;
  assign mem_we_s     = (state_q == S_RESP) & we_q & ~err_s;

  scdmem_array #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clk_i   (clk),
    .clrn_i  (clrn),
    .we_i    (mem_we_s),
    .addr_i  (diff_s[DEPTH_LOG2-1:0]),
    .wdata_i (wdata_q),
    .be_i    (be_q),
    .rdata_o (mem_rdata_s)
  );

  // Next-state and wait-counter logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          accept_s = 1'b1;
          cnt_d    = CNT_W'(WAIT);
          state_d  = (WAIT == 0) ? S_RESP : S_WAIT;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // FSM state and counter registers.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request capture on the accept edge; later input changes are ignored.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      we_q    <= 1'b0;
      addr_q  <= 32'h0000_0000;
      wdata_q <= 32'h0000_0000;
      be_q    <= 4'h0;
    end else if (accept_s) begin
      we_q    <= we;
      addr_q  <= addr;
      wdata_q <= wdata;
      be_q    <= be;
    end
  end

  // Response outputs: computed in RESP, presented in the following cycle.
  always_comb begin
    ack_d   = (state_q == S_RESP);
    busy_d  = (state_d != S_IDLE) | (state_q == S_RESP);
    err_d   = 1'b0;
    rdata_d = rdata_q;
    if (state_q == S_RESP) begin
      err_d = err_s;
      if (!we_q) begin
        rdata_d = err_s ? 32'h0000_0000 : mem_rdata_s;
      end else begin
        rdata_d = rdata_q;
      end
    end else begin
      err_d = 1'b0;
    end
  end

  // Registered output stage.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= 32'h0000_0000;
    end else begin
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      rdata_q <= rdata_d;
    end
  end

  assign ack   = ack_q;
  assign err   = err_q;
  assign busy  = busy_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_scdmem_resp.sv
// Directed bench for scdmem_resp: three instances with WAIT = 2, 0 and 5.
module tb_scdmem_resp;

  logic              clk;
  logic              clrn;
  logic [2:0]        req_s;
  logic [2:0]        we_s;
  logic [2:0][31:0]  addr_s;
  logic [2:0][31:0]  wdata_s;
  logic [2:0][3:0]   be_s;
  logic [2:0]        ack_s;
  logic [2:0][31:0]  rdata_s;
  logic [2:0]        err_s;
  logic [2:0]        busy_s;

  int n_checks;
  int n_fail;

  scdmem_resp #(.DEPTH_LOG2(6), .WAIT(2), .BASE(32'h0000_0000)) u_dut_w2 (
    .clk(clk), .clrn(clrn), .req(req_s[0]), .we(we_s[0]), .addr(addr_s[0]),
    .wdata(wdata_s[0]), .be(be_s[0]), .ack(ack_s[0]), .rdata(rdata_s[0]),
    .err(err_s[0]), .busy(busy_s[0]));

  scdmem_resp #(.DEPTH_LOG2(6), .WAIT(0), .BASE(32'h0000_0000)) u_dut_w0 (
    .clk(clk), .clrn(clrn), .req(req_s[1]), .we(we_s[1]), .addr(addr_s[1]),
    .wdata(wdata_s[1]), .be(be_s[1]), .ack(ack_s[1]), .rdata(rdata_s[1]),
    .err(err_s[1]), .busy(busy_s[1]));

  scdmem_resp #(.DEPTH_LOG2(6), .WAIT(5), .BASE(32'h0000_0000)) u_dut_w5 (
    .clk(clk), .clrn(clrn), .req(req_s[2]), .we(we_s[2]), .addr(addr_s[2]),
    .wdata(wdata_s[2]), .be(be_s[2]), .ack(ack_s[2]), .rdata(rdata_s[2]),
    .err(err_s[2]), .busy(busy_s[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One transaction on instance u. lat = edges from accept to first ack cycle.
  // With glitch set, all request inputs are scrambled one cycle after accept.
  task automatic txn(input int u, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [3:0] b, input bit glitch,
                     output logic [31:0] rd, output logic er, output int lat,
                     output logic bz0, output logic bza);
    int  k;
    bit  got;
    @(posedge clk); #1;
    req_s[u] = 1'b1; we_s[u] = w; addr_s[u] = a; wdata_s[u] = d; be_s[u] = b;
    got = 1'b0; lat = -1; rd = 32'h0; er = 1'b0; bz0 = 1'b0; bza = 1'b0;
    k = 0;
    while (!got && k < 40) begin
      @(posedge clk); #1;
      k++;
      if (k == 1) begin
        bz0 = busy_s[u];
        if (glitch) begin
          we_s[u] = ~w; addr_s[u] = a + 32'd4; wdata_s[u] = ~d; be_s[u] = 4'h0;
        end
      end
      if (ack_s[u]) begin
        got = 1'b1; lat = k - 1; rd = rdata_s[u]; er = err_s[u]; bza = busy_s[u];
        req_s[u] = 1'b0;
      end
    end
    if (!got) begin
      req_s[u] = 1'b0;
      check_value("ack_timeout", 32'(got), 32'd1);
    end
  endtask

  // Hold req high for a stream of reads; ack spacing must equal period.
  task automatic b2b(input int u, input int period, input string tag);
    int pos[3];
    int n;
    int e;
    @(posedge clk); #1;
    req_s[u] = 1'b1; we_s[u] = 1'b0; addr_s[u] = 32'h0; be_s[u] = 4'hF;
    n = 0; e = 0;
    while (n < 3 && e < 60) begin
      @(posedge clk); #1;
      e++;
      if (ack_s[u]) begin
        pos[n] = e;
        n++;
        if (n == 3) req_s[u] = 1'b0;
      end
    end
    req_s[u] = 1'b0;
    if (n < 3) begin
      check_value({tag, "_timeout"}, 32'(n), 32'd3);
    end else begin
      check_value({tag, "_gap1"}, 32'(pos[1] - pos[0]), 32'(period));
      check_value({tag, "_gap2"}, 32'(pos[2] - pos[1]), 32'(period));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er, bz0, bza;
    int          lat;
    int          acks;

    n_checks = 0; n_fail = 0;
    clrn = 1'b1;
    req_s = 3'b0; we_s = 3'b0; addr_s = '0; wdata_s = '0; be_s = '0;
    repeat (2) @(posedge clk);
    #1 clrn = 1'b0;

    // Reset state
    check_value("rst_ack",   32'(ack_s[0]),  32'd0);
    check_value("rst_err",   32'(err_s[0]),  32'd0);
    check_value("rst_busy",  32'(busy_s[0]), 32'd0);
    check_value("rst_rdata", rdata_s[0],     32'h0);

    // 1: read after reset, WAIT=2
    txn(0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, rd, er, lat, bz0, bza);
    check_value("t1_rdata", rd, 32'h0);
    check_value("t1_err",   32'(er), 32'd0);
    check_value("t1_lat",   32'(lat), 32'd3);
    check_value("t1_busy_accept", 32'(bz0), 32'd1);
    check_value("t1_busy_ack",    32'(bza), 32'd1);
    @(posedge clk); #1;
    check_value("t1_busy_after", 32'(busy_s[0]), 32'd0);
    check_value("t1_ack_once",   32'(ack_s[0]),  32'd0);

    // 2: full write then read
    txn(0, 1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 1'b0, rd, er, lat, bz0, bza);
    check_value("t2_wr_err", 32'(er), 32'd0);
    txn(0, 1'b0, 32'h08, 32'h0, 4'h0, 1'b0, rd, er, lat, bz0, bza);
    check_value("t2_rdata", rd, 32'hDEADBEEF);

    // 3: partial write, lanes 0 and 2
    txn(0, 1'b1, 32'h08, 32'h11223344, 4'b0101, 1'b0, rd, er, lat, bz0, bza);
    txn(0, 1'b0, 32'h08, 32'h0, 4'hF, 1'b0, rd, er, lat, bz0, bza);
    check_value("t3_rdata", rd, 32'hDE22BE44);
    // rdata holds across a write ack
    txn(0, 1'b1, 32'h14, 32'h00000055, 4'hF, 1'b0, rd, er, lat, bz0, bza);
    check_value("t3_rdata_hold", rdata_s[0], 32'hDE22BE44);
    // be=0 is a clean no-op
    txn(0, 1'b1, 32'h08, 32'hFFFFFFFF, 4'h0, 1'b0, rd, er, lat, bz0, bza);
    check_value("t3_be0_err", 32'(er), 32'd0);

    // 4: errors
    txn(0, 1'b1, 32'h0A, 32'hFFFFFFFF, 4'hF, 1'b0, rd, er, lat, bz0, bza);
    check_value("t4_misalign_err", 32'(er), 32'd1);
    txn(0, 1'b0, 32'h08, 32'h0, 4'hF, 1'b0, rd, er, lat, bz0, bza);
    check_value("t4_word_unchanged", rd, 32'hDE22BE44);
    txn(0, 1'b0, 32'h100, 32'h0, 4'hF, 1'b0, rd, er, lat, bz0, bza);
    check_value("t4_oor_err",   32'(er), 32'd1);
    check_value("t4_oor_rdata", rd, 32'h0);
    txn(0, 1'b0, 32'h14, 32'h0, 4'hF, 1'b0, rd, er, lat, bz0, bza);
    check_value("t4_rd14", rd, 32'h00000055);
    txn(0, 1'b0, 32'hFC, 32'h0, 4'hF, 1'b0, rd, er, lat, bz0, bza);
    check_value("t4_last_word_err", 32'(er), 32'd0);
    txn(0, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'hF, 1'b0, rd, er, lat, bz0, bza);
    check_value("t4_high_addr_err", 32'(er), 32'd1);

    // 5: latency and throughput
    txn(1, 1'b0, 32'h0, 32'h0, 4'hF, 1'b0, rd, er, lat, bz0, bza);
    check_value("t5_lat_w0", 32'(lat), 32'd1);
    txn(2, 1'b0, 32'h0, 32'h0, 4'hF, 1'b0, rd, er, lat, bz0, bza);
    check_value("t5_lat_w5", 32'(lat), 32'd6);
    b2b(1, 2, "t5_b2b_w0");
    b2b(0, 4, "t5_b2b_w2");
    b2b(2, 7, "t5_b2b_w5");

    // 6a: inputs changed during WAIT must not affect the transaction
    txn(0, 1'b1, 32'h0C, 32'h12345678, 4'hF, 1'b1, rd, er, lat, bz0, bza);
    check_value("t6_glitch_err", 32'(er), 32'd0);
    txn(0, 1'b0, 32'h0C, 32'h0, 4'hF, 1'b0, rd, er, lat, bz0, bza);
    check_value("t6_glitch_word", rd, 32'h12345678);
    txn(0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, rd, er, lat, bz0, bza);
    check_value("t6_glitch_other", rd, 32'h0);

    // 6b: reset during WAIT of a write aborts it
    @(posedge clk); #1;
    req_s[2] = 1'b1; we_s[2] = 1'b1; addr_s[2] = 32'h04; wdata_s[2] = 32'hCAFEF00D; be_s[2] = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    addr_s[2] = 32'h08;
    clrn = 1'b1;
    #3;
    req_s[2] = 1'b0;
    clrn = 1'b0;
    check_value("t6_rst_busy", 32'(busy_s[2]), 32'd0);
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (ack_s[2]) acks++;
    end
    check_value("t6_no_ack", 32'(acks), 32'd0);
    txn(2, 1'b0, 32'h04, 32'h0, 4'hF, 1'b0, rd, er, lat, bz0, bza);
    check_value("t6_word_cleared", rd, 32'h0);
    txn(0, 1'b0, 32'h08, 32'h0, 4'hF, 1'b0, rd, er, lat, bz0, bza);
    check_value("t6_array_cleared", rd, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
